// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - two-master IO bus arbiter signal bundle
interface io_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [2:0]    m0_size;
  logic          m0_ack;
  logic          m0_err;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [2:0]    m1_size;
  logic          m1_ack;
  logic          m1_err;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] io_address;
  logic [DW-1:0] io_write_value;
  logic [2:0]    io_data_size;
  logic          io_write_en;
  logic          io_read_en;
  logic [DW-1:0] io_read_value;
  logic          io_ack;

  // Arbiter side: answers both masters and drives the IO slave
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    output m1_ack, m1_err, m1_rdata,
    output io_address, io_write_value, io_data_size, io_write_en, io_read_en,
    input  io_read_value, io_ack
  );

  // Environment side: the two masters plus the IO slave
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_size,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_size,
    input  m1_ack, m1_err, m1_rdata,
    input  io_address, io_write_value, io_data_size, io_write_en, io_read_en,
    output io_read_value, io_ack
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin two-master arbiter for the IO bus with slave timeout
module io_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst_n,
  io_bus_arbiter_if.slave bus
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;     // master that wins a tie
  logic          owner_q, owner_d;   // master of the transaction in flight
  logic          we_q, we_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;   // response captured from the slave
  logic          err_q, err_d;

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wval_q, wval_d;
  logic [2:0]    size_q, size_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;

  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  logic          grant;

  // State and every output register; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wval_q  <= '0;
      size_q  <= 3'd0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wval_q  <= wval_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // Next state, grant decision and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wval_d  = wval_q;
    size_d  = size_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = err0_q;
    err1_d  = err1_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // A lone requester wins outright; a tie goes to the priority pointer
          grant   = (bus.m0_req && bus.m1_req) ? prio_q : bus.m1_req;
          owner_d = grant;
          if (grant) begin
            we_d   = bus.m1_we;
            addr_d = bus.m1_addr;
            wval_d = bus.m1_wdata;
            size_d = bus.m1_size;
          end else begin
            we_d   = bus.m0_we;
            addr_d = bus.m0_addr;
            wval_d = bus.m0_wdata;
            size_d = bus.m0_size;
          end
          // Strobe is registered so it is high exactly during ISSUE
          wen_d   = we_d;
          ren_d   = !we_d;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.io_ack) begin
          rdata_d = we_q ? '0 : bus.io_read_value;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = 8'd1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A slave ack on the final allowed cycle still wins over the timeout
        if (bus.io_ack) begin
          rdata_d = we_q ? '0 : bus.io_read_value;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TMO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (owner_q) begin
          ack1_d = 1'b1;
          err1_d = err_q;
          rd1_d  = rdata_q;
        end else begin
          ack0_d = 1'b1;
          err0_d = err_q;
          rd0_d  = rdata_q;
        end
        prio_d  = ~owner_q;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.io_address     = addr_q;
  assign bus.io_write_value = wval_q;
  assign bus.io_data_size   = size_q;
  assign bus.io_write_en    = wen_q;
  assign bus.io_read_en     = ren_q;
  assign bus.m0_ack         = ack0_q;
  assign bus.m0_err         = err0_q;
  assign bus.m0_rdata       = rd0_q;
  assign bus.m1_ack         = ack1_q;
  assign bus.m1_err         = err1_q;
  assign bus.m1_rdata       = rd1_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  io_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic          slave_ack = 1'b0;
  logic          stray_ack = 1'b0;
  logic [DW-1:0] slave_rv  = '0;
  logic [DW-1:0] stray_rv  = '0;
  assign bus.io_ack        = slave_ack | stray_ack;
  assign bus.io_read_value = slave_ack ? slave_rv : stray_rv;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    size;
  } issue_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] rdata;
    logic          err;
    int            at;
  } resp_t;

  issue_t iq[$];
  resp_t  aq[$];

  int            slave_waits = 0;          // -1: slave never answers
  logic [DW-1:0] slave_rdata = '0;

  // IO slave model: checks each issued command, then acks after slave_waits WAIT cycles
  always begin : slave_model
    issue_t e;
    @(negedge clk);
    if (rst_n && (bus.io_read_en || bus.io_write_en)) begin
      e = '{1'b0, '0, '0, 3'd0};
      if (iq.size() == 0) begin
        check("unexpected_strobe", {bus.io_write_en, bus.io_read_en}, 2'b00);
      end else begin
        e = iq.pop_front();
        check("strobe_kind", {bus.io_write_en, bus.io_read_en}, e.we ? 2'b10 : 2'b01);
        check("io_address", bus.io_address, e.addr);
        check("io_data_size", bus.io_data_size, e.size);
        if (e.we) check("io_write_value", bus.io_write_value, e.wdata);
      end
      if (slave_waits >= 0) begin
        for (int i = 0; i < slave_waits; i++) begin
          @(negedge clk);
          check("wait_strobe_low", {bus.io_write_en, bus.io_read_en}, 2'b00);
          check("wait_addr_hold", bus.io_address, e.addr);
        end
        slave_ack = 1'b1;
        slave_rv  = slave_rdata;
        @(negedge clk);
        slave_ack = 1'b0;
        slave_rv  = '0;
        check("strobe_one_cycle", {bus.io_write_en, bus.io_read_en}, 2'b00);
      end
    end
  end

  // Response scoreboard: every ack must match the oldest expectation, on the expected cycle
  always @(negedge clk) begin : ack_monitor
    resp_t r;
    if (rst_n) begin
      if (bus.m0_ack && bus.m1_ack) check("dual_ack", 1, 0);
      if (bus.m0_ack || bus.m1_ack) begin
        if (aq.size() == 0) begin
          check("unexpected_ack", {bus.m1_ack, bus.m0_ack}, 2'b00);
        end else begin
          r = aq.pop_front();
          check("ack_owner", bus.m1_ack, r.owner);
          check("ack_rdata", r.owner ? bus.m1_rdata : bus.m0_rdata, r.rdata);
          check("ack_err", r.owner ? bus.m1_err : bus.m0_err, r.err);
          check("ack_cycle", cyc, r.at);
        end
      end
    end
  end

  task automatic drive_master(input logic mst, input logic req, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [2:0] size);
    if (mst) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_size = size;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_size = size;
    end
  endtask

  task automatic set_req(input logic mst, input logic req);
    if (mst) bus.m1_req = req;
    else     bus.m0_req = req;
  endtask

  // Waits for a number of acks to one master, then drops its request in the last ack cycle
  task automatic serve(input logic mst, input int n_acks);
    int got;
    got = 0;
    for (int i = 0; i < 60 && got < n_acks; i++) begin
      @(negedge clk);
      if (mst ? bus.m1_ack : bus.m0_ack) got++;
    end
    set_req(mst, 1'b0);
    if (got < n_acks) begin
      check(mst ? "ack_wait_m1" : "ack_wait_m0", got, n_acks);
      aq.delete();
      iq.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_acks"}, {bus.m1_ack, bus.m0_ack}, 2'b00);
    check({name, "_strobes"}, {bus.io_write_en, bus.io_read_en}, 2'b00);
  endtask

  typedef struct {
    logic          mst;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    size;
    int            waits;
    logic [DW-1:0] srd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t          vecs[8];
  logic [DW-1:0] last_rd[2];
  logic          last_err[2];
  int            c;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mst   we    addr          wdata         sz    waits srd           exp_rdata     err   lat
    vecs[0] = '{1'b0, 1'b0, 32'h00000001, 32'h0,        3'd2, 0,    32'h0000A5A5, 32'h0000A5A5, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h00000004, 32'h00001234, 3'd2, 2,    32'h0000FFFF, 32'h0,        1'b0, 5};
    vecs[2] = '{1'b1, 1'b0, 32'h00000010, 32'h0,        3'd1, -1,   32'h00000077, 32'h0,        1'b1, 18};
    vecs[3] = '{1'b0, 1'b0, 32'h00000014, 32'h0,        3'd0, -1,   32'h00000066, 32'h0,        1'b1, 18};
    vecs[4] = '{1'b0, 1'b0, 32'h00000008, 32'h0,        3'd2, 1,    32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4};
    vecs[5] = '{1'b1, 1'b0, 32'h00000100, 32'h0,        3'd2, 0,    32'h13579BDF, 32'h13579BDF, 1'b0, 3};
    vecs[6] = '{1'b0, 1'b1, 32'h0000000C, 32'hFEEDFACE, 3'd2, 14,   32'h0000AAAA, 32'h0,        1'b0, 17};
    vecs[7] = '{1'b0, 1'b0, 32'h00000018, 32'h0,        3'd2, 15,   32'h00000055, 32'h00000055, 1'b0, 18};

    drive_master(1'b0, 1'b0, 1'b0, '0, '0, 3'd0);
    drive_master(1'b1, 1'b0, 1'b0, '0, '0, 3'd0);
    last_rd[0] = '0; last_rd[1] = '0; last_err[0] = 1'b0; last_err[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_acks", {bus.m1_ack, bus.m0_ack}, 2'b00);
    check("reset_rdata", {bus.m1_rdata, bus.m0_rdata}, 64'h0);
    check("reset_io_address", bus.io_address, 0);
    check("reset_strobes", {bus.io_write_en, bus.io_read_en}, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      slave_waits = vecs[k].waits;
      slave_rdata = vecs[k].srd;
      iq.push_back('{vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].size});
      aq.push_back('{vecs[k].mst, vecs[k].exp_rdata, vecs[k].exp_err, cyc + vecs[k].exp_lat});
      drive_master(vecs[k].mst, 1'b1, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].size);
      serve(vecs[k].mst, 1);
      last_rd[vecs[k].mst]  = vecs[k].exp_rdata;
      last_err[vecs[k].mst] = vecs[k].exp_err;
      // The idle master's response registers keep their last value
      check("hold_other_rdata", vecs[k].mst ? bus.m0_rdata : bus.m1_rdata, last_rd[!vecs[k].mst]);
      check("hold_other_err", vecs[k].mst ? bus.m0_err : bus.m1_err, last_err[!vecs[k].mst]);
    end

    // Stray slave ack while IDLE must not start, finish or alter anything
    @(posedge clk);
    #1;
    stray_rv  = 32'h12345678;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("stray_ack");
    end
    stray_ack = 1'b0;
    check("stray_hold_m0_rdata", bus.m0_rdata, 32'h00000055);
    check("stray_hold_m1_rdata", bus.m1_rdata, 32'h13579BDF);

    // Reset in the middle of WAIT aborts the read without an ack
    @(posedge clk);
    #1;
    slave_waits = -1;
    iq.push_back('{1'b0, 32'h00000001, 32'h0, 3'd2});
    drive_master(1'b0, 1'b1, 1'b0, 32'h00000001, '0, 3'd2);
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_wait_addr", bus.io_address, 32'h00000001);
    rst_n = 1'b0;
    #1;
    check("arst_acks", {bus.m1_ack, bus.m0_ack}, 2'b00);
    check("arst_errs", {bus.m1_err, bus.m0_err}, 2'b00);
    check("arst_rdata", {bus.m1_rdata, bus.m0_rdata}, 64'h0);
    check("arst_io_address", bus.io_address, 0);
    check("arst_io_write_value", bus.io_write_value, 0);
    check("arst_io_data_size", bus.io_data_size, 0);
    // Both masters request through reset release: m0 must win first
    drive_master(1'b0, 1'b1, 1'b1, 32'h00000040, 32'hAAAA0000, 3'd2);
    drive_master(1'b1, 1'b1, 1'b0, 32'h00000080, '0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_no_ack", {bus.m1_ack, bus.m0_ack}, 2'b00);
    end
    slave_waits = 0;
    slave_rdata = 32'h0BADBEEF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      iq.push_back('{1'b1, 32'h00000040, 32'hAAAA0000, 3'd2});
      iq.push_back('{1'b0, 32'h00000080, 32'h0, 3'd0});
      aq.push_back('{1'b0, 32'h0, 1'b0, c + 3 + 6 * i});
      aq.push_back('{1'b1, 32'h0BADBEEF, 1'b0, c + 6 + 6 * i});
    end
    fork
      serve(1'b0, 2);
      serve(1'b1, 2);
    join

    // m1 keeps requesting through its ack while m0 waits: m0 must be granted next
    @(posedge clk);
    #1;
    c = cyc;
    slave_rdata = 32'h600DF00D;
    iq.push_back('{1'b0, 32'h00000200, 32'h0, 3'd1});
    iq.push_back('{1'b0, 32'h00000300, 32'h0, 3'd2});
    iq.push_back('{1'b0, 32'h00000200, 32'h0, 3'd1});
    aq.push_back('{1'b1, 32'h600DF00D, 1'b0, c + 3});
    aq.push_back('{1'b0, 32'h600DF00D, 1'b0, c + 6});
    aq.push_back('{1'b1, 32'h600DF00D, 1'b0, c + 9});
    drive_master(1'b1, 1'b1, 1'b0, 32'h00000200, '0, 3'd1);
    @(posedge clk);
    #1;
    drive_master(1'b0, 1'b1, 1'b0, 32'h00000300, '0, 3'd2);
    fork
      serve(1'b1, 2);
      serve(1'b0, 1);
    join

    repeat (4) @(posedge clk);
    #1;
    check("acks_outstanding", aq.size(), 0);
    check("issues_outstanding", iq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Shares the single memory-mapped IO bus (switches, buttons, LEDs) between two masters: port 0, the Risc32 core, and port 1, an auxiliary master such as a debug/UART loader. It sequences one transaction at a time onto the IO slave, tolerates variable slave latency through an ack handshake, and returns an error on slave timeout. It sits between the masters and the IO decode logic in top.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max cycles in WAIT without s_ack before error (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request, level, held until m0_ack
m0_we  in  1  master 0 write (1) / read (0)
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_size  in  3  master 0 data size code, passed through
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack; 1 = timeout
m0_rdata  out  DW  read data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_size, m1_ack, m1_err, m1_rdata  as m0_*, master 1
io_address  out  AW  slave address
io_write_value  out  DW  slave write data
io_data_size  out  3  slave size code
io_write_en  out  1  one-cycle write strobe
io_read_en  out  1  one-cycle read strobe
io_read_value  in  DW  slave read data, sampled with io_ack
io_ack  in  1  slave completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (acks, errs, rdata, strobes, io_address, io_write_value, io_data_size); priority pointer = master 0; timeout counter 0. In-flight transaction dropped, no ack issued. Release is synchronous to clk.
- States IDLE, ISSUE, WAIT, RESP; all outputs registered.
- IDLE: no req -> stay. Exactly one req -> grant it. Both -> grant master at priority pointer. On grant latch we/addr/wdata/size/owner into io_* registers; -> ISSUE.
- ISSUE (1 cycle): io_write_en or io_read_en = 1 per latched we. If io_ack=1 this cycle, capture io_read_value -> RESP, err=0; else -> WAIT, counter=1.
- WAIT: strobes 0; io_address/io_write_value/io_data_size held stable. io_ack=1 -> capture io_read_value, err=0, -> RESP. Else if counter==TIMEOUT -> rdata=0, err=1, -> RESP. Else counter+1 (8-bit, no wrap reachable).
- RESP (1 cycle): owner's mX_ack=1, mX_err and mX_rdata driven; other master's ack=0. Priority pointer := non-owner (round robin). -> IDLE.
- Writes: rdata returned as 0.
- mX_rdata/mX_err hold their value until the next ack to that master.
- Latency, zero-wait slave (ack in ISSUE): req sampled at edge N -> ISSUE during N..N+1 -> ack high during cycle after edge N+2. Each wait cycle adds 1. Back-to-back min period 3 cycles per transaction.
- Master drops req at the edge ending its ack cycle; req still high in IDLE = new transaction.
- io_ack in IDLE or RESP ignored. Master req changes while not in IDLE ignored (values already latched).
- Simultaneous req from both: strict alternation; neither starves.

Test Plan:
- Reset: rst_n=0 mid-WAIT (m0 read addr 0x1) -> all outputs 0 immediately, m0_ack never pulses; after release m0 req re-granted, pointer=m0.
- m0 read addr 0x00000001, slave acks in ISSUE with 0x0000A5A5 -> io_read_en one cycle, m0_ack pulses 3 cycles after req, m0_rdata=0x0000A5A5, m0_err=0.
- m1 write addr 0x4 data 0x1234, slave acks after 2 wait cycles -> io_write_en one cycle, io_address held 0x4 through WAIT, m1_ack 5 cycles after req, m1_rdata=0.
- Both req continuously from reset -> grants m0,m1,m0,m1 with zero-wait slave; one ack every 3 cycles, alternating.
- Slave never acks, TIMEOUT=15 -> m0_ack with m0_err=1, m0_rdata=0 after 15 WAIT cycles; late io_ack in IDLE ignored.
- m1 ack cycle with m0 req pending -> next grant m0 even if m1 re-requests immediately.
